svc_rv_dmem_bridge: RTL and testbench
=====================================

SVC_RV_DMEM_BRIDGE -- requirements
Module: svc_rv_dmem_bridge

Interface
REQ-001 SHALL have parameter AW, default 32, bus/core address width.
REQ-002 SHALL have parameter DW, default 32, data width; DW/8 strobe bits.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports dmem_ren  input  1, dmem_raddr  input  AW, dmem_rdata  output  DW  core load request and data.
REQ-006 SHALL have ports dmem_we  input  1, dmem_waddr  input  AW, dmem_wdata  input  DW, dmem_wstrb  input  DW/8  core store request.
REQ-007 SHALL have port dmem_stall  output  1  core hold; while high, core holds pipeline and request inputs are ignored.
REQ-008 SHALL have ports bus_valid  output  1, bus_ready  input  1, bus_we  output  1, bus_addr  output  AW, bus_wdata  output  DW, bus_wstrb  output  DW/8  request channel.
REQ-009 SHALL have ports bus_rvalid  input  1, bus_rdata  input  DW  read response channel.

Function
REQ-010 SHALL accept a core request in any cycle with dmem_stall low and dmem_ren or dmem_we high, capturing address, data and strobe into registers.
REQ-011 SHALL implement states IDLE, WR_REQ, RD_REQ, RD_WAIT; IDLE->WR_REQ on accepted write, IDLE->RD_REQ on accepted read-only.
REQ-012 SHALL, when ren and we are accepted together, issue the write first then the read (WR_REQ->RD_REQ after write handshake).
REQ-013 SHALL assert bus_valid in WR_REQ and RD_REQ only, with bus_we=1 in WR_REQ, 0 in RD_REQ; bus_wstrb=0 for reads.
REQ-014 SHALL hold bus_addr/bus_we/bus_wdata/bus_wstrb stable while bus_valid && !bus_ready.
REQ-015 SHALL transfer on bus_valid && bus_ready; WR_REQ->IDLE (or RD_REQ if read pending), RD_REQ->RD_WAIT.
REQ-016 SHALL ignore bus_rvalid outside RD_WAIT; in RD_WAIT on bus_rvalid SHALL register bus_rdata into dmem_rdata and return to IDLE.
REQ-017 SHALL drive dmem_stall high in every non-IDLE state and low in IDLE (registered from state, no combinational path from bus inputs).
REQ-018 SHALL hold dmem_rdata constant except on the REQ-016 capture, giving BRAM-style 1-cycle-after-release timing to the core.
REQ-019 SHALL issue at most one bus transaction outstanding; no new acceptance until IDLE.

Reset
REQ-020 SHALL, on rst_n low, asynchronously enter IDLE with bus_valid=0, dmem_stall=0, dmem_rdata=0, all capture registers and write buffer cleared.
REQ-021 SHALL abandon any in-flight transaction on reset mid-operation; a bus_rvalid after reset release SHALL be ignored.

Configuration
REQ-022 SHALL honour macro SVC_RV_DMEM_BRIDGE_WBUF_EN.
REQ-023 With SVC_RV_DMEM_BRIDGE_WBUF_EN defined: one-entry posted write buffer; accepted write-only does not stall, is drained from IDLE via WR_REQ in background; a read or write accepted while buffer occupied SHALL stall until drained, preserving program order.
REQ-024 Without the macro: every write stalls the core until its bus handshake completes (REQ-011..015 only).

Structure
REQ-025 SHALL place the state enum (IDLE, WR_REQ, RD_REQ, RD_WAIT) in shared package svc_rv_pkg.
REQ-026 SHALL implement the write buffer as sub-module svc_rv_dmem_wbuf, instantiated only under SVC_RV_DMEM_BRIDGE_WBUF_EN.

Verification
REQ-027 Read, bus_ready=1, rvalid 2 cycles later with 0xDEADBEEF, raddr 0x100 -> bus_addr=0x100, dmem_stall high 3 cycles, dmem_rdata=0xDEADBEEF then held.
REQ-028 Write 0x12345678 wstrb 0xF addr 0x40, bus_ready low 3 cycles -> bus_valid held 4 cycles with stable payload, stall released after handshake (macro off).
REQ-029 Simultaneous ren addr 0x80 and we addr 0x84 -> bus write to 0x84 precedes read of 0x80; rvalid data 0xA5A5A5A5 delivered.
REQ-030 rst_n low while in RD_WAIT, later spurious bus_rvalid with 0xFFFFFFFF -> outputs at reset values, dmem_rdata stays 0.
REQ-031 Macro on: write to 0x10 then immediate read 0x10 with bus_ready low 2 cycles -> no stall on write, read stalls until write drained, write precedes read on bus.
REQ-032 Formal: bus_valid never drops or changes payload without bus_ready; dmem_rdata changes only on rvalid in RD_WAIT.

Source files
------------

// File: rtl/svc_rv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | svc_rv_pkg : shared data-memory bridge state encoding   Rev 1.0  |
// +------------------------------------------------------------------+
package svc_rv_pkg;

    typedef logic [1:0] dmem_state_t;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WR_REQ  = 2'd1;
    localparam logic [1:0] RD_REQ  = 2'd2;
    localparam logic [1:0] RD_WAIT = 2'd3;

    function automatic logic is_bus_state(input logic [1:0] s);
        return (s == WR_REQ) || (s == RD_REQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/svc_rv_dmem_wbuf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | svc_rv_dmem_wbuf : one-entry posted store buffer        Rev 1.0  |
// +------------------------------------------------------------------+
module svc_rv_dmem_wbuf
    import svc_rv_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   data_i,
    input  logic [DW/8-1:0] strb_i,
    output logic            valid_o,
    output logic [AW-1:0]   addr_o,
    output logic [DW-1:0]   data_o,
    output logic [DW/8-1:0] strb_o
);

    logic            valid_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic [DW/8-1:0] strb_q;

    // Push is only issued while empty and pop only while full, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else if (push_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            data_q  <= data_i;
            strb_q  <= strb_i;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign strb_o  = strb_q;

endmodule
`default_nettype wire

// File: rtl/svc_rv_dmem_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | svc_rv_dmem_bridge : core dmem port to valid/ready bus  Rev 1.0  |
// | SVC_RV_DMEM_BRIDGE_WBUF_EN enables the posted store buffer       |
// +------------------------------------------------------------------+
module svc_rv_dmem_bridge
    import svc_rv_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dmem_ren,
    input  logic [AW-1:0]   dmem_raddr,
    output logic [DW-1:0]   dmem_rdata,
    input  logic            dmem_we,
    input  logic [AW-1:0]   dmem_waddr,
    input  logic [DW-1:0]   dmem_wdata,
    input  logic [DW/8-1:0] dmem_wstrb,
    output logic            dmem_stall,
    output logic            bus_valid,
    input  logic            bus_ready,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_wstrb,
    input  logic            bus_rvalid,
    input  logic [DW-1:0]   bus_rdata
);

    localparam int SW = DW / 8;

    logic [1:0]    state_q, state_d;
    logic          stall_q, stall_d;
    logic          pend_re_q, pend_re_d;
    logic [AW-1:0] raddr_q;
    logic [DW-1:0] rdata_q;

    logic          w_accept;
    logic          w_direct;
    logic          w_hs;
    logic          w_pend_we;
    logic          w_stall_next;
    logic          w_wb_push;
    logic          w_wb_pop;
    logic          w_wb_valid;
    logic [AW-1:0] w_wb_addr;
    logic [DW-1:0] w_wb_data;
    logic [SW-1:0] w_wb_strb;

    assign w_accept = !stall_q && (dmem_ren || dmem_we);
    // An empty store buffer implies IDLE, so a direct accept can start the bus at once.
    assign w_direct = w_accept && !w_wb_valid;
    assign w_hs     = bus_valid && bus_ready;
    assign w_wb_pop = (state_q == WR_REQ) && w_hs;

`ifdef SVC_RV_DMEM_BRIDGE_WBUF_EN
    logic          pend_we_q, pend_we_d;
    logic [AW-1:0] pwaddr_q;
    logic [DW-1:0] pwdata_q;
    logic [SW-1:0] pwstrb_q;
    logic          w_push_pend;
    logic          w_defer_we;

    // A store arriving while the buffer is full waits here, stalling the core.
    assign w_defer_we  = w_accept && dmem_we && w_wb_valid;
    assign w_push_pend = (state_q == IDLE) && !w_wb_valid && pend_we_q;
    assign w_wb_push   = (w_direct && dmem_we) || w_push_pend;
    assign w_pend_we   = pend_we_q;

    always_comb begin
        pend_we_d = pend_we_q;
        if (w_defer_we) begin
            pend_we_d = 1'b1;
        end else if (w_push_pend) begin
            pend_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_we_q <= 1'b0;
            pwaddr_q  <= '0;
            pwdata_q  <= '0;
            pwstrb_q  <= '0;
        end else begin
            pend_we_q <= pend_we_d;
            if (w_defer_we) begin
                pwaddr_q <= dmem_waddr;
                pwdata_q <= dmem_wdata;
                pwstrb_q <= dmem_wstrb;
            end
        end
    end

    svc_rv_dmem_wbuf #(
        .AW (AW),
        .DW (DW)
    ) u_wbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_wb_push),
        .pop_i   (w_wb_pop),
        .addr_i  (w_direct ? dmem_waddr : pwaddr_q),
        .data_i  (w_direct ? dmem_wdata : pwdata_q),
        .strb_i  (w_direct ? dmem_wstrb : pwstrb_q),
        .valid_o (w_wb_valid),
        .addr_o  (w_wb_addr),
        .data_o  (w_wb_data),
        .strb_o  (w_wb_strb)
    );

    // Posted stores leave the core running; only waiting requests and reads hold it.
    assign w_stall_next = pend_we_d || pend_re_d ||
                          (state_d == RD_REQ) || (state_d == RD_WAIT);
`else
    logic          wb_valid_q;
    logic [AW-1:0] wb_addr_q;
    logic [DW-1:0] wb_data_q;
    logic [SW-1:0] wb_strb_q;

    assign w_wb_push = w_direct && dmem_we;
    assign w_pend_we = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_strb_q  <= '0;
        end else if (w_wb_push) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= dmem_waddr;
            wb_data_q  <= dmem_wdata;
            wb_strb_q  <= dmem_wstrb;
        end else if (w_wb_pop) begin
            wb_valid_q <= 1'b0;
        end
    end

    assign w_wb_valid   = wb_valid_q;
    assign w_wb_addr    = wb_addr_q;
    assign w_wb_data    = wb_data_q;
    assign w_wb_strb    = wb_strb_q;
    assign w_stall_next = (state_d != IDLE);
`endif

    always_comb begin
        pend_re_d = pend_re_q;
        if (w_accept && dmem_ren) begin
            pend_re_d = 1'b1;
        end else if ((state_q == RD_REQ) && w_hs) begin
            pend_re_d = 1'b0;
        end
    end

    // Program order: buffered store, then deferred store, then the read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_direct) begin
                    state_d = dmem_we ? WR_REQ : RD_REQ;
                end else if (w_wb_valid || w_pend_we) begin
                    state_d = WR_REQ;
                end else if (pend_re_q) begin
                    state_d = RD_REQ;
                end
            end
            WR_REQ: begin
                if (w_hs) begin
                    state_d = (!w_pend_we && pend_re_q) ? RD_REQ : IDLE;
                end
            end
            RD_REQ: begin
                if (w_hs) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_d = w_stall_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            stall_q   <= 1'b0;
            pend_re_q <= 1'b0;
            raddr_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            pend_re_q <= pend_re_d;
            if (w_accept && dmem_ren) begin
                raddr_q <= dmem_raddr;
            end
            if ((state_q == RD_WAIT) && bus_rvalid) begin
                rdata_q <= bus_rdata;
            end
        end
    end

    assign bus_valid  = is_bus_state(state_q);
    assign bus_we     = (state_q == WR_REQ);
    assign bus_addr   = (state_q == WR_REQ) ? w_wb_addr : raddr_q;
    assign bus_wdata  = (state_q == WR_REQ) ? w_wb_data : '0;
    assign bus_wstrb  = (state_q == WR_REQ) ? w_wb_strb : '0;
    assign dmem_stall = stall_q;
    assign dmem_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_svc_rv_dmem_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_svc_rv_dmem_bridge : directed bench for the dmem bridge       |
// +------------------------------------------------------------------+
module tb_svc_rv_dmem_bridge;

    logic        clk;
    logic        rst_n;
    logic        dmem_ren;
    logic [31:0] dmem_raddr;
    logic [31:0] dmem_rdata;
    logic        dmem_we;
    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_stall;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;

    svc_rv_dmem_bridge #(
        .AW (32),
        .DW (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dmem_ren   (dmem_ren),
        .dmem_raddr (dmem_raddr),
        .dmem_rdata (dmem_rdata),
        .dmem_we    (dmem_we),
        .dmem_waddr (dmem_waddr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_stall (dmem_stall),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        dmem_ren   = 1'b0;
        dmem_raddr = '0;
        dmem_we    = 1'b0;
        dmem_waddr = '0;
        dmem_wdata = '0;
        dmem_wstrb = '0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;

        tick();
        tick();
        chk("reset_valid", 32'(bus_valid), 32'd0);
        chk("reset_stall", 32'(dmem_stall), 32'd0);
        chk("reset_rdata", dmem_rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // Read 0x100, ready=1, rvalid in second RD_WAIT cycle
        dmem_ren   = 1'b1;
        dmem_raddr = 32'h100;
        bus_ready  = 1'b1;
        chk("rd_pre_stall", 32'(dmem_stall), 32'd0);
        tick();
        dmem_ren   = 1'b0;
        dmem_raddr = 32'h999;
        chk("rd_valid", 32'(bus_valid), 32'd1);
        chk("rd_we", 32'(bus_we), 32'd0);
        chk("rd_addr", bus_addr, 32'h100);
        chk("rd_wstrb", 32'(bus_wstrb), 32'd0);
        chk("rd_stall1", 32'(dmem_stall), 32'd1);
        tick();
        chk("rd_wait_valid", 32'(bus_valid), 32'd0);
        chk("rd_stall2", 32'(dmem_stall), 32'd1);
        tick();
        chk("rd_stall3", 32'(dmem_stall), 32'd1);
        chk("rd_rdata_before", dmem_rdata, 32'h0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEADBEEF;
        tick();
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h11111111;
        chk("rd_rdata", dmem_rdata, 32'hDEADBEEF);
        chk("rd_stall_release", 32'(dmem_stall), 32'd0);
        tick();
        chk("rd_rdata_held", dmem_rdata, 32'hDEADBEEF);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h55555555;
        tick();
        bus_rvalid = 1'b0;
        chk("idle_rvalid_ignored", dmem_rdata, 32'hDEADBEEF);
        chk("idle_rvalid_valid", 32'(bus_valid), 32'd0);

`ifndef SVC_RV_DMEM_BRIDGE_WBUF_EN
        // Write with backpressure: valid held 4 cycles, payload stable
        dmem_we    = 1'b1;
        dmem_waddr = 32'h40;
        dmem_wdata = 32'h12345678;
        dmem_wstrb = 4'hF;
        bus_ready  = 1'b0;
        tick();
        dmem_we    = 1'b0;
        dmem_waddr = 32'hBAD0;
        dmem_wdata = 32'hBAD0BAD0;
        dmem_wstrb = 4'h1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus_ready = 1'b1;
            chk($sformatf("wr_valid_%0d", i), 32'(bus_valid), 32'd1);
            chk($sformatf("wr_we_%0d", i), 32'(bus_we), 32'd1);
            chk($sformatf("wr_addr_%0d", i), bus_addr, 32'h40);
            chk($sformatf("wr_data_%0d", i), bus_wdata, 32'h12345678);
            chk($sformatf("wr_strb_%0d", i), 32'(bus_wstrb), 32'hF);
            chk($sformatf("wr_stall_%0d", i), 32'(dmem_stall), 32'd1);
            tick();
        end
        chk("wr_done_valid", 32'(bus_valid), 32'd0);
        chk("wr_done_stall", 32'(dmem_stall), 32'd0);
`endif

        // Simultaneous store 0x84 and load 0x80: store first
        dmem_ren   = 1'b1;
        dmem_raddr = 32'h80;
        dmem_we    = 1'b1;
        dmem_waddr = 32'h84;
        dmem_wdata = 32'hCAFEF00D;
        dmem_wstrb = 4'h3;
        bus_ready  = 1'b1;
        tick();
        dmem_ren = 1'b0;
        dmem_we  = 1'b0;
        chk("rw_first_we", 32'(bus_we), 32'd1);
        chk("rw_first_addr", bus_addr, 32'h84);
        chk("rw_first_data", bus_wdata, 32'hCAFEF00D);
        chk("rw_first_strb", 32'(bus_wstrb), 32'h3);
        tick();
        chk("rw_second_valid", 32'(bus_valid), 32'd1);
        chk("rw_second_we", 32'(bus_we), 32'd0);
        chk("rw_second_addr", bus_addr, 32'h80);
        chk("rw_second_stall", 32'(dmem_stall), 32'd1);
        tick();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hA5A5A5A5;
        tick();
        bus_rvalid = 1'b0;
        chk("rw_rdata", dmem_rdata, 32'hA5A5A5A5);
        chk("rw_stall", 32'(dmem_stall), 32'd0);

        // Reset while in RD_WAIT, then spurious rvalid
        dmem_ren   = 1'b1;
        dmem_raddr = 32'h200;
        tick();
        dmem_ren = 1'b0;
        tick();
        chk("rst_pre_stall", 32'(dmem_stall), 32'd1);
        chk("rst_pre_valid", 32'(bus_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_stall", 32'(dmem_stall), 32'd0);
        chk("rst_async_rdata", dmem_rdata, 32'h0);
        tick();
        rst_n      = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFFFFFF;
        tick();
        bus_rvalid = 1'b0;
        tick();
        chk("rst_post_rdata", dmem_rdata, 32'h0);
        chk("rst_post_stall", 32'(dmem_stall), 32'd0);
        chk("rst_post_valid", 32'(bus_valid), 32'd0);

`ifdef SVC_RV_DMEM_BRIDGE_WBUF_EN
        // Posted store to 0x10, then load 0x10 behind it
        dmem_we    = 1'b1;
        dmem_waddr = 32'h10;
        dmem_wdata = 32'h0BADF00D;
        dmem_wstrb = 4'hF;
        bus_ready  = 1'b0;
        tick();
        dmem_we    = 1'b0;
        dmem_ren   = 1'b1;
        dmem_raddr = 32'h10;
        chk("wb_no_stall", 32'(dmem_stall), 32'd0);
        chk("wb_valid", 32'(bus_valid), 32'd1);
        chk("wb_we", 32'(bus_we), 32'd1);
        tick();
        dmem_ren = 1'b0;
        chk("wb_rd_stall", 32'(dmem_stall), 32'd1);
        chk("wb_still_write", 32'(bus_we), 32'd1);
        tick();
        chk("wb_hold_addr", bus_addr, 32'h10);
        chk("wb_hold_data", bus_wdata, 32'h0BADF00D);
        bus_ready = 1'b1;
        tick();
        chk("wb_read_we", 32'(bus_we), 32'd0);
        chk("wb_read_valid", 32'(bus_valid), 32'd1);
        chk("wb_read_addr", bus_addr, 32'h10);
        tick();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h00000077;
        tick();
        bus_rvalid = 1'b0;
        chk("wb_rdata", dmem_rdata, 32'h00000077);
        chk("wb_release", 32'(dmem_stall), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
